// File: rtl/dcache_pkg.sv
// Purpose : shared types and address-split helpers for the N-way data cache.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
// Ports   : none. DCACHE_PERF_EN is consumed by nway_dcache, not by this package.
package dcache_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_e;

  // Byte-offset bits within one line.
  function automatic int off_w(input int line_words);
    return $clog2(line_words * WORD_BYTES);
  endfunction

  // Set-index bits.
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Whatever is left of the 32-bit address above offset and index.
  function automatic int tag_w(input int line_words, input int sets);
    return 32 - off_w(line_words) - idx_w(sets);
  endfunction

endpackage

// File: rtl/dcache_way_ram.sv
// Purpose : one cache way -- valid bits, tag array and line data array.
// Latency : read is combinational by index/word; writes land on the rising edge.
// Backpr. : none; the owner decides when to write.
// Ports   : clk, rst (sync, active-high, clears valid only); rd_idx/rd_word -> rd_valid/rd_tag/rd_data;
//           wr_en/wr_idx/wr_word/wr_data write one word; tag_we/wr_tag write the tag and set valid.
module dcache_way_ram
  import dcache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 22
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(SETS)-1:0]       rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [31:0]                   rd_data,
  input  logic                          wr_en,
  input  logic [$clog2(SETS)-1:0]       wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [31:0]                   wr_data,
  input  logic                          tag_we,
  input  logic [TAG_W-1:0]              wr_tag
);

  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS][LINE_WORDS];
  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  valid_d;

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx][rd_word];

  always_comb begin
    valid_d = valid_q;
    if (tag_we) valid_d[wr_idx] = 1'b1;
  end

  // Tag and data are deliberately not cleared; valid alone gates hits.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
    if (!rst && wr_en)  data_mem[wr_idx][wr_word] <= wr_data;
    if (!rst && tag_we) tag_mem[wr_idx] <= wr_tag;
  end

endmodule

// File: rtl/nway_dcache.sv
// Purpose : N-way set-associative write-through, no-write-allocate data cache for the rv32 access stage.
// Latency : load hit returns data in the request cycle; miss stalls for LINE_WORDS+1 cycles on a zero-wait bus.
// Backpr. : o_stall freezes the core while busy; the bus request is held until mem_ack for each beat.
// Ports   : clk, rst; core side i_req/i_we/i_addr/i_wdata -> o_rdata/o_stall;
//           bus side mem_req/mem_we/mem_addr/mem_wdata <- mem_ack/mem_rdata.
//           `define DCACHE_PERF_EN adds o_hit_cnt/o_miss_cnt load hit/miss counters.
module nway_dcache
  import dcache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt
`endif
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(LINE_WORDS, SETS);
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(LINE_WORDS - 1);

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [WRD_W-1:0] word;
  logic             unused_addr_bits;

  assign tag  = i_addr[31:OFF_W+IDX_W];
  assign idx  = i_addr[OFF_W+IDX_W-1:OFF_W];
  assign word = i_addr[OFF_W-1:2];
  assign unused_addr_bits = ^i_addr[1:0];

  // Way array
  logic [WAYS-1:0]  way_valid;
  logic [WAYS-1:0]  hit_vec;
  logic [TAG_W-1:0] way_tag   [WAYS];
  logic [31:0]      way_rdata [WAYS];
  logic [WAYS-1:0]  ram_we;
  logic [WAYS-1:0]  ram_tag_we;
  logic [WRD_W-1:0] ram_wr_word;
  logic [31:0]      ram_wr_data;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_way_ram #(
      .SETS      (SETS),
      .LINE_WORDS(LINE_WORDS),
      .TAG_W     (TAG_W)
    ) u_way (
      .clk     (clk),
      .rst     (rst),
      .rd_idx  (idx),
      .rd_word (word),
      .rd_valid(way_valid[g]),
      .rd_tag  (way_tag[g]),
      .rd_data (way_rdata[g]),
      .wr_en   (ram_we[g]),
      .wr_idx  (idx),
      .wr_word (ram_wr_word),
      .wr_data (ram_wr_data),
      .tag_we  (ram_tag_we[g]),
      .wr_tag  (tag)
    );
    assign hit_vec[g] = way_valid[g] && (way_tag[g] == tag);
  end

  logic        hit_any;
  logic [31:0] hit_data;

  assign hit_any = |hit_vec;

  // At most one way can hit, so an AND-OR mux is enough.
  always_comb begin
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_data = hit_data | (way_rdata[w] & {32{hit_vec[w]}});
    end
  end

  assign o_rdata = (i_req && !i_we && hit_any) ? hit_data : '0;

  // FSM and control state
  state_e           state_q,   state_d;
  logic [WRD_W-1:0] beat_q,    beat_d;
  logic [WAY_W-1:0] victim_q,  victim_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q,  mem_we_d;
  logic [WAY_W-1:0] rr_q [SETS];
  logic [WAY_W-1:0] rr_d [SETS];
  logic [WAY_W-1:0] victim_sel;
  logic             refill_done;

  // Lowest invalid way wins; only a full set falls back to round-robin.
  always_comb begin
    logic found;
    found      = 1'b0;
    victim_sel = rr_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!way_valid[w] && !found) begin
        victim_sel = WAY_W'(w);
        found      = 1'b1;
      end
    end
  end

  assign refill_done = (state_q == REFILL) && mem_ack && (beat_q == LAST_BEAT);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    victim_d    = victim_q;
    rr_d        = rr_q;
    o_stall     = 1'b0;
    ram_we      = '0;
    ram_tag_we  = '0;
    ram_wr_word = beat_q;
    ram_wr_data = mem_rdata;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          if (i_we) begin
            o_stall = 1'b1;
            state_d = WRITE;
          end else if (!hit_any) begin
            o_stall  = 1'b1;
            state_d  = REFILL;
            beat_d   = '0;
            victim_d = victim_sel;
          end
        end
      end
      REFILL: begin
        o_stall = 1'b1;
        if (mem_ack) begin
          ram_we[victim_q] = 1'b1;
          beat_d           = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            ram_tag_we[victim_q] = 1'b1;
            state_d              = IDLE;
            beat_d               = '0;
            rr_d[idx]            = (WAYS == 1) ? '0 : WAY_W'(rr_q[idx] + 1'b1);
          end
        end
      end
      WRITE: begin
        // The store retires in its ack cycle, so the stall drops there.
        o_stall     = !mem_ack;
        ram_wr_word = word;
        ram_wr_data = i_wdata;
        if (mem_ack) begin
          ram_we  = hit_vec;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d != IDLE);
    mem_we_d  = (state_d == WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      victim_q  <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      victim_q  <= victim_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      rr_q      <= rr_d;
    end
  end

  // Bus outputs depend only on registered state, the beat counter and the held request.
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = (state_q == WRITE) ? {i_addr[31:2], 2'b00} : {tag, idx, beat_q, 2'b00};
  assign mem_wdata = i_wdata;

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt_q,  hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        retry_q,    retry_d;

  // retry_q marks the IDLE cycle right after a refill, whose hit is the replay of an already counted miss.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    retry_d    = retry_q;
    if (state_q == IDLE) begin
      retry_d = 1'b0;
      if (i_req && !i_we) begin
        if (hit_any && !retry_q) hit_cnt_d  = hit_cnt_q + 32'd1;
        if (!hit_any)            miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
    if (refill_done) retry_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      retry_q    <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      retry_q    <= retry_d;
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`else
  logic unused_refill_done;
  assign unused_refill_done = refill_done;
`endif

endmodule

// File: tb/tb_nway_dcache.sv
// Purpose : self-checking bench for nway_dcache (WAYS=2, SETS=64, LINE_WORDS=4) with a zero-wait bus model.
// Latency : bus acks in the first cycle of every request; refill data equals the word address.
// Backpr. : bus transactions are checked against a queue of expected transfers pushed per access.
module tb_nway_dcache;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef DCACHE_PERF_EN
  logic [31:0] o_hit_cnt;
  logic [31:0] o_miss_cnt;
`endif

  nway_dcache #(
    .WAYS      (2),
    .SETS      (64),
    .LINE_WORDS(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_we     (i_we),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .o_rdata  (o_rdata),
    .o_stall  (o_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
`ifdef DCACHE_PERF_EN
    ,
    .o_hit_cnt (o_hit_cnt),
    .o_miss_cnt(o_miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory: every requested beat is acked at once, read data = word address.
  assign mem_ack   = mem_req;
  assign mem_rdata = mem_addr;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        miss;
    int          stall;
    logic [31:0] rdata;
  } vec_t;

  bus_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_access(input vec_t v);
    bus_t        b;
    logic [31:0] base;
    if (v.we) begin
      b.we = 1'b1; b.addr = {v.addr[31:2], 2'b00}; b.data = v.wdata;
      exp_q.push_back(b);
    end else if (v.miss) begin
      base = {v.addr[31:4], 4'h0};
      for (int k = 0; k < 4; k++) begin
        b.we = 1'b0; b.addr = base + 32'(k * 4); b.data = b.addr;
        exp_q.push_back(b);
      end
    end
  endtask

  // Bus monitor: every acked beat must match the head of the expectation queue.
  always @(negedge clk) begin
    bus_t e;
    if (!rst && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL bus_unexpected: got we=%0b addr=%h, expected no transfer", mem_we, mem_addr);
      end else begin
        e = exp_q.pop_front();
        chk("bus_we", {31'b0, mem_we}, {31'b0, e.we});
        chk("bus_addr", mem_addr, e.addr);
        if (e.we) chk("bus_wdata", mem_wdata, e.data);
      end
    end
  end

  task automatic do_access(input vec_t v, input string tag);
    int cyc;
    bit done;
    push_access(v);
    @(posedge clk); #1;
    i_req = 1'b1; i_we = v.we; i_addr = v.addr; i_wdata = v.wdata;
    cyc  = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (o_stall) cyc++;
      else begin
        done = 1'b1;
        chk({tag, "_stall_cycles"}, 32'(cyc), 32'(v.stall));
        if (!v.we) chk({tag, "_rdata"}, o_rdata, v.rdata);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got stall still high, expected release within 40 cycles", tag);
    end
    @(posedge clk); #1;
    i_req = 1'b0; i_we = 1'b0;
    chk({tag, "_bus_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   found;
    vec_t v;

    // {we, addr, wdata, miss, stall cycles, load data}
    vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,          1'b1, 5, 32'h0000_0100}; // cold miss
    vecs[1]  = '{1'b0, 32'h0000_0104, 32'h0,          1'b0, 0, 32'h0000_0104}; // hit
    vecs[2]  = '{1'b1, 32'h0000_0108, 32'hDEAD_BEEF,  1'b0, 1, 32'h0};         // store hit
    vecs[3]  = '{1'b0, 32'h0000_0108, 32'h0,          1'b0, 0, 32'hDEAD_BEEF}; // updated word
    vecs[4]  = '{1'b0, 32'h0000_010C, 32'h0,          1'b0, 0, 32'h0000_010C};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,          1'b1, 5, 32'h0000_0000}; // set 0, way 0
    vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0,          1'b1, 5, 32'h0000_1000}; // set 0, way 1
    vecs[7]  = '{1'b0, 32'h0000_2000, 32'h0,          1'b1, 5, 32'h0000_2000}; // evicts way 0
    vecs[8]  = '{1'b0, 32'h0000_1000, 32'h0,          1'b0, 0, 32'h0000_1000}; // survivor hits
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,          1'b1, 5, 32'h0000_0000}; // evicted line misses
    vecs[10] = '{1'b1, 32'h0000_4000, 32'h1234_5678,  1'b0, 1, 32'h0};         // store miss, no allocate
    vecs[11] = '{1'b0, 32'h0000_4000, 32'h0,          1'b1, 5, 32'h0000_4000}; // still a miss
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,          1'b0, 0, 32'h0000_0000};
    vecs[13] = '{1'b1, 32'h0000_0104, 32'hCAFE_F00D,  1'b0, 1, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_0104, 32'h0,          1'b0, 0, 32'hCAFE_F00D};

    rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset_mem_we",  {31'b0, mem_we},  32'd0);
    chk("reset_o_stall", {31'b0, o_stall}, 32'd0);
    chk("reset_o_rdata", o_rdata, 32'd0);

    for (int i = 0; i < 15; i++) do_access(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a refill: abandon it and leave the line invalid.
    v = '{1'b0, 32'h0000_0200, 32'h0, 1'b1, 5, 32'h0000_0200};
    push_access(v);
    void'(exp_q.pop_back()); // the last beat never happens
    @(posedge clk); #1;
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0200;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h0000_0208) found = 1'b1;
    end
    chk("midrst_reached_beat2", {31'b0, found}, 32'd1);
    #1 rst = 1'b1; i_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_o_stall", {31'b0, o_stall}, 32'd0);
    chk("midrst_bus_pending", 32'(exp_q.size()), 32'd0);
    do_access(v, "midrst_reload");

`ifdef DCACHE_PERF_EN
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    do_access('{1'b0, 32'h0000_0300, 32'h0,    1'b1, 5, 32'h0000_0300}, "perf_miss");
    do_access('{1'b0, 32'h0000_0300, 32'h0,    1'b0, 0, 32'h0000_0300}, "perf_hit0");
    do_access('{1'b0, 32'h0000_0304, 32'h0,    1'b0, 0, 32'h0000_0304}, "perf_hit1");
    do_access('{1'b1, 32'h0000_0300, 32'h5A5A, 1'b0, 1, 32'h0},         "perf_store");
    @(negedge clk);
    chk("perf_miss_cnt", o_miss_cnt, 32'd1);
    chk("perf_hit_cnt",  o_hit_cnt,  32'd2);
`endif

    repeat (2) @(posedge clk);
    chk("final_bus_pending", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nway_dcache.md
# nway_dcache

Parametrised N-way set-associative data cache between the access stage of the rv32 pipeline and the data memory bus. It replaces the direct dmem hookup. Loads are serviced in the access cycle on a hit; misses are refilled over a word-per-beat handshake bus. Stores are write-through and no-write-allocate. While the cache is busy it raises a core stall that freezes the pipeline.

## Interface
- WAYS, 2, associativity; power of two, 1..8
- SETS, 64, sets per way; power of two
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  access valid this cycle (load or store)
- i_we  in  1  1 = store word, 0 = load word
- i_addr  in  32  byte address; bits [1:0] ignored
- i_wdata  in  32  store data
- o_rdata  out  32  load data, valid when i_req & !i_we & !o_stall
- o_stall  out  1  hold pipeline; core keeps i_* stable while high
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned bus address
- mem_wdata  out  32  bus write data
- mem_ack  in  1  one-cycle beat acknowledge
- mem_rdata  in  32  refill word, valid with mem_ack

## Operation
- Address split: offset = log2(LINE_WORDS*4) bits, index = log2(SETS) bits, tag = the remaining upper bits.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - Load hit: o_rdata comes combinationally from the hitting way, o_stall=0.
  - Load miss: o_stall=1 and the FSM moves to REFILL.
  - Store, hit or miss: o_stall=1 and the FSM moves to WRITE.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, beat, 2'b00}.
  - The beat counter starts at 0 and increments on each mem_ack. Each acked word is written into the victim way.
  - On the ack of the last beat, the tag is written, valid is set and the FSM returns to IDLE. The held request then hits.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = i_addr word-aligned, mem_wdata = i_wdata.
  - On mem_ack: if the line hits, the word is also updated in the cache. The FSM returns to IDLE with the store retired. o_stall drops in the ack cycle.
- Victim selection: the lowest-numbered invalid way. If every way is valid, the per-set round-robin pointer chooses, and the pointer advances by 1 mod WAYS on each completed refill of that set.
- o_stall: high whenever state≠IDLE, except in the final WRITE ack cycle. Also high in IDLE on a load miss or on any store.
- Reset: state=IDLE, all valid bits=0, round-robin pointers=0, beat counter=0.
  - mem_req=0, mem_we=0, o_stall=0 (with i_req=0), o_rdata=0.
  - Data and tag arrays are not cleared.
  - Reset mid-REFILL or mid-WRITE abandons the transaction. mem_req is low from the cycle after the reset edge, and the partial line stays invalid.
- i_req=0 in IDLE: no action and o_stall=0.

## Timing
- Load hit: zero added latency, and the data is in the same cycle as the request.
- Load miss with zero-wait bus (mem_ack in the first cycle of each mem_req beat): o_stall is high for exactly LINE_WORDS+1 cycles, and the data is presented in the next cycle with o_stall=0.
- Store with zero-wait bus: o_stall is high for 1 cycle (the IDLE cycle). The ack cycle retires the store.
- mem_* outputs are driven from state and counters only, with no combinational path from mem_ack to mem_req.
- mem_req never deasserts before mem_ack, except on rst.

## Configuration
- DCACHE_PERF_EN defined adds two outputs, o_hit_cnt and o_miss_cnt, each 32 bits:
  - Load hit increments o_hit_cnt once, in the IDLE decision cycle.
  - Load miss increments o_miss_cnt once; the post-refill retry hit is not counted.
  - Stores are not counted.
  - Counters wrap modulo 2^32 and clear on rst.
- DCACHE_PERF_EN undefined: the ports and counters are absent, and all other behaviour is identical.

## Structure
- Package dcache_pkg:
  - State enum {IDLE, REFILL, WRITE}.
  - Width helper functions for the offset, index and tag widths.
  - Constant WORD_BYTES=4.
- Sub-module dcache_way_ram, instantiated WAYS times:
  - Per-way valid bits, tag array and data array.
  - Asynchronous read by index; synchronous write by index and word.
  - Valid bits clear on rst.
- The top level holds the FSM, hit compare, victim select, round-robin pointers, beat counter and perf counters.

## Test plan
- Cold load from 0x0000_0100, zero-wait bus with mem_rdata = address → mem reads of 0x100, 0x104, 0x108, 0x10C; o_stall high for 5 cycles; then o_rdata=0x100.
- Load 0x104 immediately after → hit, o_stall=0, o_rdata=0x104, no mem_req.
- Store 0xDEAD_BEEF to 0x108 (hit) → one mem write to 0x108. A following load of 0x108 hits and returns 0xDEAD_BEEF. A store to uncached 0x4000 writes the bus only, and a later load of 0x4000 misses.
- WAYS=2, SETS=64: loads to 0x0000, 0x1000, 0x2000 (same set) → third load evicts the way-0 line. A reload of 0x0000 misses, while a reload of 0x1000 hits.
- Assert rst during beat 2 of a refill → mem_req=0 on the next cycle, state=IDLE. A reload of the same address misses and refills all 4 beats.
- DCACHE_PERF_EN, sequence miss, hit, hit, store → o_miss_cnt=1, o_hit_cnt=2.
